// File: rtl/spi_pkg.sv
// Shared constants for the SPI command receiver: SUMP opcodes, FSM encoding
// and the byte width.
package spi_pkg;

  localparam int BYTE_W = 8;

  localparam logic [7:0] OP_RESET       = 8'h00;
  localparam logic [7:0] OP_RUN         = 8'h01;
  localparam logic [7:0] OP_QUERY_ID    = 8'h02;
  localparam logic [7:0] OP_QUERY_META  = 8'h04;
  localparam logic [7:0] OP_QUERY_INPUT = 8'h06;

  typedef enum logic [1:0] {
    READOPCODE = 2'd0,
    READLONG   = 2'd1,
    EXECUTE    = 2'd2
  } state_e;

endpackage

// File: rtl/spi_receiver_if.sv
// SPI pins from the host plus the decoded command outputs of the receiver.
interface spi_receiver_if;
  import spi_pkg::*;

  logic              sclk;
  logic              mosi;
  logic              cs;
  logic [BYTE_W-1:0] opcode;
  logic [31:0]       opdata;
  logic              execute;
  logic              query_id;
  logic              query_dataIn;
  logic              sump_reset;
  logic              byte_strobe;

  modport master (
    output sclk, mosi, cs,
    input  opcode, opdata, execute, query_id, query_dataIn, sump_reset, byte_strobe
  );

  modport slave (
    input  sclk, mosi, cs,
    output opcode, opdata, execute, query_id, query_dataIn, sump_reset, byte_strobe
  );
endinterface

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizes sclk/mosi/cs, detects rising
// sclk and shifts bytes in MSB-first while cs is low.
module spi_byte_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              extReset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_strobe
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   dly_sclk_q, dly_sclk_d;
  logic [2:0]             bits_q, bits_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic                   byte_strobe_q, byte_strobe_d;

  logic sclk_s, mosi_s, cs_s, rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~dly_sclk_q;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs};
    dly_sclk_d    = sclk_s;
    bits_d        = bits_q;
    shift_d       = shift_q;
    byte_strobe_d = 1'b0;
    // Deselect drops any partial byte; the command layer is left untouched.
    if (cs_s) begin
      bits_d = 3'd0;
    end else if (rise) begin
      shift_d       = {shift_q[BYTE_W-2:0], mosi_s};
      bits_d        = bits_q + 3'd1;
      byte_strobe_d = (bits_q == 3'd7);
    end
  end

  // Synchronizers preset high so an idle bus looks like sclk high, cs deasserted.
  always_ff @(posedge clock) begin
    if (extReset) begin
      sclk_sync_q   <= '1;
      mosi_sync_q   <= '1;
      cs_sync_q     <= '1;
      dly_sclk_q    <= 1'b1;
      bits_q        <= 3'd0;
      shift_q       <= '0;
      byte_strobe_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      dly_sclk_q    <= dly_sclk_d;
      bits_q        <= bits_d;
      shift_q       <= shift_d;
      byte_strobe_q <= byte_strobe_d;
    end
  end

  assign rx_byte     = shift_q;
  assign byte_strobe = byte_strobe_q;

endmodule

// File: rtl/spi_receiver.sv
// SUMP command decoder: assembles short (1 byte) and long (5 byte) commands
// from the SPI byte stream and issues execute plus per-opcode pulses.
module spi_receiver
  import spi_pkg::*;
#(
  parameter logic [23:0] TIMEOUT     = 24'd10000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic     clock,
  input  logic     extReset,
  spi_receiver_if.slave bus
);

  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT - 24'd1;

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_strobe;

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] opcode_q, opcode_d;
  logic [31:0]       opdata_q, opdata_d;
  logic [1:0]        bytecnt_q, bytecnt_d;
  logic [23:0]       timeout_q, timeout_d;
  logic              execute, query_id, query_data_in, sump_reset;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clock       (clock),
    .extReset    (extReset),
    .sclk        (bus.sclk),
    .mosi        (bus.mosi),
    .cs          (bus.cs),
    .rx_byte     (rx_byte),
    .byte_strobe (byte_strobe)
  );

  always_ff @(posedge clock) begin
    if (extReset) begin
      state_q   <= READOPCODE;
      opcode_q  <= '0;
      opdata_q  <= '0;
      bytecnt_q <= 2'd0;
      timeout_q <= 24'd0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      opdata_q  <= opdata_d;
      bytecnt_q <= bytecnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    opdata_d  = opdata_q;
    bytecnt_d = bytecnt_q;
    timeout_d = timeout_q;
    case (state_q)
      READOPCODE: begin
        timeout_d = 24'd0;
        if (byte_strobe) begin
          opcode_d  = rx_byte;
          opdata_d  = '0;
          bytecnt_d = 2'd0;
          state_d   = rx_byte[7] ? READLONG : EXECUTE;
        end
      end
      READLONG: begin
        // A byte arriving on the expiry cycle still counts.
        if (byte_strobe) begin
          opdata_d[{bytecnt_q, 3'b000} +: 8] = rx_byte;
          bytecnt_d = bytecnt_q + 2'd1;
          timeout_d = 24'd0;
          if (bytecnt_q == 2'd3) state_d = EXECUTE;
        end else if (timeout_q >= TIMEOUT_LAST) begin
          state_d = READOPCODE;
        end else if (timeout_q != '1) begin
          timeout_d = timeout_q + 24'd1;
        end
      end
      EXECUTE: begin
        timeout_d = 24'd0;
        state_d   = READOPCODE;
      end
      default: state_d = READOPCODE;
    endcase
  end

  always_comb begin
    execute       = (state_q == EXECUTE);
    query_id      = execute && (opcode_q == OP_QUERY_ID);
    query_data_in = execute && (opcode_q == OP_QUERY_INPUT);
    sump_reset    = execute && (opcode_q == OP_RESET);
  end

  assign bus.opcode       = opcode_q;
  assign bus.opdata       = opdata_q;
  assign bus.execute      = execute;
  assign bus.query_id     = query_id;
  assign bus.query_dataIn = query_data_in;
  assign bus.sump_reset   = sump_reset;
  assign bus.byte_strobe  = byte_strobe;

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: short/long commands, cs abort, timeout,
// back-to-back resets and reset mid-command.
module tb_spi_receiver;

  localparam int HP = 3;

  logic clock = 1'b0;
  logic ext_reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int          exec_cnt = 0;
  int          qid_cnt = 0;
  int          qdi_cnt = 0;
  int          srst_cnt = 0;
  int          strobe_cnt = 0;
  logic [7:0]  last_op = 8'hxx;
  logic [31:0] last_data = 32'hxxxxxxxx;

  int e0, q0, s0, b0;

  always #5 clock = ~clock;

  spi_receiver_if bus ();

  spi_receiver #(.TIMEOUT(24'd100), .SYNC_STAGES(2)) dut (
    .clock    (clock),
    .extReset (ext_reset),
    .bus      (bus)
  );

  always @(negedge clock) begin
    if (bus.execute) begin
      exec_cnt  <= exec_cnt + 1;
      last_op   <= bus.opcode;
      last_data <= bus.opdata;
    end
    if (bus.query_id)     qid_cnt    <= qid_cnt + 1;
    if (bus.query_dataIn) qdi_cnt    <= qdi_cnt + 1;
    if (bus.sump_reset)   srst_cnt   <= srst_cnt + 1;
    if (bus.byte_strobe)  strobe_cnt <= strobe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clock);
      bus.sclk = 1'b0;
      bus.mosi = b[i];
      repeat (HP) @(negedge clock);
      bus.sclk = 1'b1;
      repeat (HP - 1) @(negedge clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic settle();
    repeat (8) @(negedge clock);
  endtask

  initial begin
    bus.sclk = 1'b1;
    bus.mosi = 1'b1;
    bus.cs   = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_opcode", {24'd0, bus.opcode}, 32'd0);
    chk("rst_opdata", bus.opdata, 32'd0);
    chk("rst_execute", {31'd0, bus.execute}, 32'd0);
    chk("rst_strobe", {31'd0, bus.byte_strobe}, 32'd0);
    ext_reset = 1'b0;
    repeat (3) @(negedge clock);

    // Short command: query ID
    bus.cs = 1'b0;
    repeat (4) @(negedge clock);
    send_byte(8'h02);
    settle();
    chk("qid_exec", exec_cnt, 1);
    chk("qid_opcode", {24'd0, last_op}, 32'h02);
    chk("qid_opdata", last_data, 32'd0);
    chk("qid_pulse", qid_cnt, 1);
    chk("qid_qdi", qdi_cnt, 0);
    chk("qid_srst", srst_cnt, 0);

    // Long command, little-endian argument
    e0 = exec_cnt;
    send_byte(8'hC0);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    settle();
    chk("long_no_exec_4", exec_cnt - e0, 0);
    send_byte(8'h12);
    settle();
    chk("long_exec", exec_cnt - e0, 1);
    chk("long_opcode", {24'd0, last_op}, 32'hC0);
    chk("long_opdata", last_data, 32'h12345678);

    // cs abort after 5 bits, then query input
    e0 = exec_cnt;
    send_bits(8'hFF, 5);
    repeat (2) @(negedge clock);
    bus.cs = 1'b1;
    repeat (6) @(negedge clock);
    bus.cs = 1'b0;
    repeat (4) @(negedge clock);
    send_byte(8'h06);
    settle();
    chk("csab_exec", exec_cnt - e0, 1);
    chk("csab_opcode", {24'd0, last_op}, 32'h06);
    chk("csab_qdi", qdi_cnt, 1);

    // Timeout discards partial long command
    e0 = exec_cnt;
    send_byte(8'h81);
    send_byte(8'hAA);
    repeat (100) @(negedge clock);
    chk("tmo_no_exec", exec_cnt - e0, 0);
    send_byte(8'h01);
    settle();
    chk("tmo_exec", exec_cnt - e0, 1);
    chk("tmo_opcode", {24'd0, last_op}, 32'h01);
    chk("tmo_opdata", last_data, 32'd0);

    // Five consecutive reset opcodes
    e0 = exec_cnt;
    s0 = srst_cnt;
    b0 = strobe_cnt;
    for (int k = 0; k < 5; k++) send_byte(8'h00);
    settle();
    chk("b2b_exec", exec_cnt - e0, 5);
    chk("b2b_srst", srst_cnt - s0, 5);
    chk("b2b_strobes", strobe_cnt - b0, 5);

    // Reset during the 3rd argument byte of a long command
    send_byte(8'h80);
    send_byte(8'h11);
    send_byte(8'h22);
    send_bits(8'h33, 4);
    @(negedge clock);
    ext_reset = 1'b1;
    bus.cs    = 1'b1;
    bus.sclk  = 1'b1;
    repeat (2) @(negedge clock);
    chk("mrst_opcode", {24'd0, bus.opcode}, 32'd0);
    chk("mrst_opdata", bus.opdata, 32'd0);
    chk("mrst_execute", {31'd0, bus.execute}, 32'd0);
    chk("mrst_pulses", {28'd0, bus.query_id, bus.query_dataIn, bus.sump_reset, bus.byte_strobe}, 32'd0);
    ext_reset = 1'b0;
    repeat (3) @(negedge clock);
    e0 = exec_cnt;
    q0 = qid_cnt;
    bus.cs = 1'b0;
    repeat (4) @(negedge clock);
    send_byte(8'h02);
    settle();
    chk("mrst_exec", exec_cnt - e0, 1);
    chk("mrst_after_opcode", {24'd0, last_op}, 32'h02);
    chk("mrst_after_opdata", last_data, 32'd0);
    chk("mrst_after_qid", qid_cnt - q0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
